c2h_pkt_gen: RTL and testbench
==============================

C2H_PKT_GEN -- requirements
Module: c2h_pkt_gen

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 256, meaning AXI-S data width in bits (multiple of 32).
REQ-002 The block SHALL have parameter PKT_WORDS_LEN, default 8, meaning beats per packet (2..255).
REQ-003 The block SHALL have port clk  input  1  clock; all logic is rising-edge.
REQ-004 The block SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 The block SHALL have port start  input  1  single-cycle run request.
REQ-006 The block SHALL have port stop  input  1  single-cycle stop request.
REQ-007 The block SHALL have port num_pkts  input  16  packets per run; 0 = unlimited.
REQ-008 The block SHALL have port gap_cycles  input  8  idle cycles between packets.
REQ-009 The block SHALL have port m_axis_tvalid  output  1  beat valid toward C2H FIFO.
REQ-010 The block SHALL have port m_axis_tready  input  1  FIFO ready.
REQ-011 The block SHALL have port m_axis_tdata  output  DATA_WIDTH  beat payload.
REQ-012 The block SHALL have port m_axis_tlast  output  1  last beat of packet.
REQ-013 The block SHALL have port busy  output  1  run in progress.
REQ-014 The block SHALL have port pkts_sent  output  16  packets completed in current or last run.
REQ-015 The block SHALL have port done  output  1  one-cycle pulse at run end.

Function
REQ-016 The block SHALL implement FSM states IDLE, SEND, GAP.
REQ-017 In IDLE, start SHALL latch num_pkts and gap_cycles, clear pkts_sent, set sequence number to 1, clear beat counter, and enter SEND next cycle.
REQ-018 start in SEND or GAP SHALL be ignored.
REQ-019 In SEND, m_axis_tvalid SHALL be 1; tdata/tlast SHALL stay stable until handshake (tvalid & tready).
REQ-020 Each 32-bit lane i of beat b in packet with sequence s SHALL equal {s[15:0], b[7:0], i[7:0]}.
REQ-021 m_axis_tlast SHALL be 1 exactly when beat counter == PKT_WORDS_LEN-1.
REQ-022 On last-beat handshake: pkts_sent += 1, sequence += 1 (16-bit wrap), beat counter -> 0.
REQ-023 After last-beat handshake, the FSM SHALL go to IDLE with done=1 for one cycle if stop was pending or pkts_sent+1 == latched num_pkts (num_pkts != 0).
REQ-024 Otherwise, it SHALL go to GAP if latched gap_cycles != 0, else stay in SEND with next beat offered the following cycle (no bubble).
REQ-025 GAP SHALL hold tvalid=0 for exactly latched gap_cycles cycles, then enter SEND.
REQ-026 A stop pulse in SEND SHALL be recorded as pending; the current packet SHALL always complete (never truncated).
REQ-027 A stop pulse in GAP SHALL go to IDLE next cycle with done=1.
REQ-028 A stop pulse in IDLE SHALL be ignored; pending stop SHALL clear on entering IDLE.
REQ-029 start and stop in the same IDLE cycle SHALL start a run (stop ignored).
REQ-030 busy SHALL be 1 in SEND and GAP, else 0.
REQ-031 With num_pkts = 0, pkts_sent SHALL wrap 0xFFFF -> 0x0000 and the run SHALL end only on stop.

Reset
REQ-032 On rst_n=0 at a clock edge: state IDLE, m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, busy=0, done=0, pkts_sent=0, pending stop cleared, sequence=1.
REQ-033 Reset mid-packet SHALL drop tvalid the next cycle without completing the packet.

Structure
REQ-034 The state enum and the lane-pattern function SHALL reside in shared package c2h_pkt_gen_pkg.
REQ-035 No sub-module SHALL be used; the block is a single module.

Verification
REQ-036 The bench SHALL cover: num_pkts=2, gap=0, tready=1 -> 16 consecutive beats, tlast on beats 7 and 15, lane0 of beat 0 = 0x00010000, of beat 8 = 0x00020000, done at cycle after beat 15, pkts_sent=2.
REQ-037 The bench SHALL cover: gap=3, num_pkts=2 -> exactly 3 tvalid=0 cycles between packets.
REQ-038 The bench SHALL cover: random tready toggling -> tdata/tlast stable while tvalid & !tready; all beats received in order.
REQ-039 The bench SHALL cover: num_pkts=0, stop at beat 3 of packet 5 -> packet 5 completes, done, pkts_sent=5.
REQ-040 The bench SHALL cover: stop in GAP, and start while busy -> IDLE next cycle with done; start ignored, pkts_sent unchanged.
REQ-041 The bench SHALL cover: rst_n low at beat 4 -> tvalid=0 next cycle; next start begins at sequence 1, beat 0.

Source files
------------

// File: rtl/c2h_pkt_gen_pkg.sv
// Shared types and beat payload pattern for the C2H packet generator.
package c2h_pkt_gen_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SEND = 2'd1,
      GAP  = 2'd2
   } state_e;

   function automatic logic [31:0] lane_word(
      input logic [15:0] seq,
      input logic [7:0]  beat,
      input logic [7:0]  lane
   );
      return {seq, beat, lane};
   endfunction

endpackage

// File: rtl/c2h_pkt_gen.sv
// Synthetic C2H packet source: fixed-length AXI-S packets with
// sequence-tagged lanes, programmable packet count and inter-packet gap.
module c2h_pkt_gen
   import c2h_pkt_gen_pkg::*;
#(
   parameter int DATA_WIDTH    = 256,
   parameter int PKT_WORDS_LEN = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic                  stop,
   input  logic [15:0]           num_pkts,
   input  logic [7:0]            gap_cycles,
   output logic                  m_axis_tvalid,
   input  logic                  m_axis_tready,
   output logic [DATA_WIDTH-1:0] m_axis_tdata,
   output logic                  m_axis_tlast,
   output logic                  busy,
   output logic [15:0]           pkts_sent,
   output logic                  done
);

   localparam int         LANES     = DATA_WIDTH / 32;
   localparam logic [7:0] LAST_BEAT = 8'(PKT_WORDS_LEN - 1);

   state_e      state_q, state_d;
   logic [15:0] num_q, num_d;
   logic [7:0]  gap_q, gap_d;
   logic [7:0]  gcnt_q, gcnt_d;
   logic [15:0] seq_q, seq_d;
   logic [7:0]  beat_q, beat_d;
   logic [15:0] pkts_q, pkts_d;
   logic        pend_q, pend_d;
   logic        done_q, done_d;

   logic        is_send;
   logic        hs;
   logic        last_beat;
   logic [15:0] pkts_inc;
   logic        end_run;
   logic [DATA_WIDTH-1:0] pattern;

   for (genvar i = 0; i < LANES; i++) begin : g_lane
      assign pattern[i*32 +: 32] = lane_word(seq_q, beat_q, 8'(i));
   end

   assign is_send   = (state_q == SEND);
   assign last_beat = (beat_q == LAST_BEAT);
   assign hs        = is_send & m_axis_tready;
   assign pkts_inc  = pkts_q + 16'd1;
   // A stop arriving on the final handshake counts as already pending.
   assign end_run   = pend_q | stop |
                      ((num_q != 16'd0) && (pkts_inc == num_q));

   assign m_axis_tvalid = is_send;
   assign m_axis_tlast  = is_send & last_beat;
   assign m_axis_tdata  = is_send ? pattern : '0;
   assign busy          = (state_q != IDLE);
   assign pkts_sent     = pkts_q;
   assign done          = done_q;

   always_comb begin
      state_d = state_q;
      num_d   = num_q;
      gap_d   = gap_q;
      gcnt_d  = gcnt_q;
      seq_d   = seq_q;
      beat_d  = beat_q;
      pkts_d  = pkts_q;
      pend_d  = pend_q;
      done_d  = 1'b0;
      unique case (state_q)
         IDLE: begin
            pend_d = 1'b0;
            if (start) begin
               num_d   = num_pkts;
               gap_d   = gap_cycles;
               pkts_d  = 16'd0;
               seq_d   = 16'd1;
               beat_d  = 8'd0;
               state_d = SEND;
            end
         end
         SEND: begin
            if (stop) pend_d = 1'b1;
            if (hs) begin
               if (last_beat) begin
                  pkts_d = pkts_inc;
                  seq_d  = seq_q + 16'd1;
                  beat_d = 8'd0;
                  if (end_run) begin
                     state_d = IDLE;
                     done_d  = 1'b1;
                     pend_d  = 1'b0;
                  end else if (gap_q != 8'd0) begin
                     state_d = GAP;
                     gcnt_d  = gap_q;
                  end
               end else begin
                  beat_d = beat_q + 8'd1;
               end
            end
         end
         GAP: begin
            if (stop) begin
               state_d = IDLE;
               done_d  = 1'b1;
               pend_d  = 1'b0;
            end else if (gcnt_q <= 8'd1) begin
               state_d = SEND;
            end else begin
               gcnt_d = gcnt_q - 8'd1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         num_q   <= 16'd0;
         gap_q   <= 8'd0;
         gcnt_q  <= 8'd0;
         seq_q   <= 16'd1;
         beat_q  <= 8'd0;
         pkts_q  <= 16'd0;
         pend_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         num_q   <= num_d;
         gap_q   <= gap_d;
         gcnt_q  <= gcnt_d;
         seq_q   <= seq_d;
         beat_q  <= beat_d;
         pkts_q  <= pkts_d;
         pend_q  <= pend_d;
         done_q  <= done_d;
      end
   end

endmodule

// File: tb/tb_c2h_pkt_gen.sv
// Randomized self-checking bench for c2h_pkt_gen against a
// packet-stream reference model.
module tb_c2h_pkt_gen;

   localparam int DW  = 256;
   localparam int LEN = 8;
   localparam int MAXC = 400;

   logic          clk;
   logic          rst_n;
   logic          start;
   logic          stop;
   logic [15:0]   num_pkts;
   logic [7:0]    gap_cycles;
   logic          tvalid;
   logic          tready;
   logic [DW-1:0] tdata;
   logic          tlast;
   logic          busy;
   logic [15:0]   pkts_sent;
   logic          done;

   int tests = 0;
   int fails = 0;

   logic          tv [MAXC];
   logic          tl [MAXC];
   logic          rd [MAXC];
   logic          dn [MAXC];
   logic          bz [MAXC];
   logic [15:0]   ps [MAXC];
   logic [DW-1:0] td [MAXC];

   c2h_pkt_gen #(.DATA_WIDTH(DW), .PKT_WORDS_LEN(LEN)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .start         (start),
      .stop          (stop),
      .num_pkts      (num_pkts),
      .gap_cycles    (gap_cycles),
      .m_axis_tvalid (tvalid),
      .m_axis_tready (tready),
      .m_axis_tdata  (tdata),
      .m_axis_tlast  (tlast),
      .busy          (busy),
      .pkts_sent     (pkts_sent),
      .done          (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [DW-1:0] exp_word(input logic [15:0] s, input int b);
      logic [DW-1:0] w;
      for (int i = 0; i < DW / 32; i++) w[i*32 +: 32] = {s, 8'(b), 8'(i)};
      return w;
   endfunction

   task automatic launch(input logic [15:0] n, input logic [7:0] g, input logic stp);
      @(negedge clk);
      start = 1'b1;
      stop = stp;
      num_pkts = n;
      gap_cycles = g;
      tready = 1'b1;
   endtask

   // Drive inputs and capture outputs for n cycles (index k = k-th negedge).
   task automatic record(input int n, input int pct, input int st_a, input int st_b,
                         input int sp_at, input int rs_at);
      for (int k = 0; k < n; k++) begin
         @(negedge clk);
         tready = ($urandom_range(99) < pct);
         start = (k == st_a) || (k == st_b);
         stop = (k == sp_at);
         rst_n = !(k == rs_at);
         num_pkts = 16'($urandom);
         gap_cycles = 8'($urandom);
         tv[k] = tvalid; tl[k] = tlast; rd[k] = tready;
         dn[k] = done; bz[k] = busy; ps[k] = pkts_sent; td[k] = tdata;
      end
      start = 1'b0; stop = 1'b0; rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      tests++; if (tvalid !== 1'b0) begin fails++; $display("FAIL reset_tvalid got %0b exp 0", tvalid); end
      tests++; if (tlast !== 1'b0) begin fails++; $display("FAIL reset_tlast got %0b exp 0", tlast); end
      tests++; if (tdata !== '0) begin fails++; $display("FAIL reset_tdata got %h exp 0", tdata); end
      tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %0b exp 0", busy); end
      tests++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done got %0b exp 0", done); end
      tests++; if (pkts_sent !== 16'd0) begin fails++; $display("FAIL reset_pkts got %0d exp 0", pkts_sent); end
      rst_n = 1'b1;
      @(negedge clk); stop = 1'b1;
      @(negedge clk); stop = 1'b0;
      @(negedge clk);
      tests++; if (busy !== 1'b0 || done !== 1'b0 || tvalid !== 1'b0) begin
         fails++; $display("FAIL idle_stop busy=%0b done=%0b tvalid=%0b exp 0/0/0", busy, done, tvalid);
      end
   endtask

   task automatic test_basic();
      logic [DW-1:0] w;
      launch(16'd2, 8'd0, 1'b0);
      record(20, 100, -1, -1, -1, -1);
      for (int k = 0; k < 16; k++) begin
         tests++; if (tv[k] !== 1'b1) begin fails++; $display("FAIL basic_tv[%0d] got %0b exp 1", k, tv[k]); end
         tests++; if (tl[k] !== ((k % LEN) == LEN - 1)) begin
            fails++; $display("FAIL basic_tl[%0d] got %0b exp %0b", k, tl[k], (k % LEN) == LEN - 1);
         end
         tests++; if (td[k] !== exp_word(16'(k / LEN + 1), k % LEN)) begin
            fails++; $display("FAIL basic_td[%0d] got %h exp %h", k, td[k], exp_word(16'(k / LEN + 1), k % LEN));
         end
      end
      w = td[0];
      tests++; if (w[31:0] !== 32'h0001_0000) begin fails++; $display("FAIL basic_lane0_b0 got %h exp 00010000", w[31:0]); end
      w = td[8];
      tests++; if (w[31:0] !== 32'h0002_0000) begin fails++; $display("FAIL basic_lane0_b8 got %h exp 00020000", w[31:0]); end
      tests++; if (dn[15] !== 1'b0 || dn[16] !== 1'b1 || dn[17] !== 1'b0) begin
         fails++; $display("FAIL basic_done got %0b%0b%0b exp 010", dn[15], dn[16], dn[17]);
      end
      tests++; if (ps[16] !== 16'd2) begin fails++; $display("FAIL basic_pkts got %0d exp 2", ps[16]); end
      tests++; if (tv[16] !== 1'b0 || bz[16] !== 1'b0) begin
         fails++; $display("FAIL basic_end tv=%0b busy=%0b exp 0/0", tv[16], bz[16]);
      end
   endtask

   task automatic test_gap();
      int g, first_last, next_v;
      for (int pass = 0; pass < 2; pass++) begin
         g = (pass == 0) ? 3 : $urandom_range(1, 9);
         launch(16'd2, 8'(g), 1'b0);
         record(40, 100, -1, -1, -1, -1);
         first_last = -1; next_v = -1;
         for (int k = 0; k < 40; k++) begin
            if (first_last < 0 && tv[k] && tl[k]) first_last = k;
            else if (first_last >= 0 && next_v < 0 && tv[k]) next_v = k;
         end
         tests++; if (next_v - first_last - 1 != g) begin
            fails++; $display("FAIL gap_len got %0d exp %0d", next_v - first_last - 1, g);
         end
         tests++; if (first_last + 1 < 40 && bz[first_last + 1] !== 1'b1) begin
            fails++; $display("FAIL gap_busy got %0b exp 1", bz[first_last + 1]);
         end
         tests++; if (next_v >= 0 && td[next_v] !== exp_word(16'd2, 0)) begin
            fails++; $display("FAIL gap_next got %h exp %h", td[next_v], exp_word(16'd2, 0));
         end
         tests++; if (dn[2 * LEN + g] !== 1'b1 || ps[2 * LEN + g] !== 16'd2) begin
            fails++; $display("FAIL gap_done got %0b pkts %0d exp 1 pkts 2", dn[2 * LEN + g], ps[2 * LEN + g]);
         end
      end
   endtask

   task automatic test_backpressure();
      int g, nbeats, ndone, sq, bt, gapcnt;
      bit in_gap;
      g = $urandom_range(0, 2);
      launch(16'd3, 8'(g), 1'b0);
      record(300, 50, -1, -1, -1, -1);
      nbeats = 0; ndone = 0; sq = 1; bt = 0; in_gap = 0; gapcnt = 0;
      for (int k = 0; k < 300; k++) begin
         if (tv[k] && !rd[k] && k + 1 < 300) begin
            tests++; if (tv[k+1] !== 1'b1 || td[k+1] !== td[k] || tl[k+1] !== tl[k]) begin
               fails++; $display("FAIL bp_stable[%0d] tv=%0b tl=%0b->%0b exp held", k, tv[k+1], tl[k], tl[k+1]);
            end
         end
         if (in_gap) begin
            if (!tv[k] && !dn[k]) gapcnt++;
            else begin
               in_gap = 0;
               tests++; if (!dn[k] && gapcnt != g) begin fails++; $display("FAIL bp_gap got %0d exp %0d", gapcnt, g); end
            end
         end
         if (tv[k] && rd[k]) begin
            nbeats++;
            tests++; if (td[k] !== exp_word(16'(sq), bt) || tl[k] !== (bt == LEN - 1)) begin
               fails++; $display("FAIL bp_beat seq %0d beat %0d got %h tl=%0b", sq, bt, td[k], tl[k]);
            end
            if (bt == LEN - 1) begin bt = 0; sq++; in_gap = 1; gapcnt = 0; end
            else bt++;
         end
         if (dn[k]) begin
            ndone++;
            tests++; if (ps[k] !== 16'd3) begin fails++; $display("FAIL bp_pkts got %0d exp 3", ps[k]); end
         end
      end
      tests++; if (nbeats != 3 * LEN) begin fails++; $display("FAIL bp_nbeats got %0d exp %0d", nbeats, 3 * LEN); end
      tests++; if (ndone != 1) begin fails++; $display("FAIL bp_ndone got %0d exp 1", ndone); end
   endtask

   task automatic test_stop_send();
      int nbeats, ndone;
      launch(16'd0, 8'd0, 1'b0);
      record(50, 100, -1, -1, 4 * LEN + 3, -1);
      nbeats = 0; ndone = 0;
      for (int k = 0; k < 50; k++) begin
         if (tv[k]) begin
            nbeats++;
            tests++; if (td[k] !== exp_word(16'(k / LEN + 1), k % LEN)) begin
               fails++; $display("FAIL stop_td[%0d] got %h exp %h", k, td[k], exp_word(16'(k / LEN + 1), k % LEN));
            end
         end
         if (dn[k]) ndone++;
      end
      tests++; if (nbeats != 5 * LEN) begin fails++; $display("FAIL stop_nbeats got %0d exp %0d", nbeats, 5 * LEN); end
      tests++; if (ndone != 1 || dn[5 * LEN] !== 1'b1) begin
         fails++; $display("FAIL stop_done count %0d at40 %0b exp 1/1", ndone, dn[5 * LEN]);
      end
      tests++; if (ps[5 * LEN] !== 16'd5) begin fails++; $display("FAIL stop_pkts got %0d exp 5", ps[5 * LEN]); end
      tests++; if (ps[LEN] !== 16'd1) begin fails++; $display("FAIL stop_pkts1 got %0d exp 1", ps[LEN]); end
   endtask

   task automatic test_stop_gap();
      launch(16'd0, 8'd4, 1'b0);
      record(14, 100, 3, 9, 10, -1);
      for (int k = 0; k < LEN; k++) begin
         tests++; if (tv[k] !== 1'b1 || td[k] !== exp_word(16'd1, k)) begin
            fails++; $display("FAIL sg_beat[%0d] tv=%0b got %h exp %h", k, tv[k], td[k], exp_word(16'd1, k));
         end
      end
      tests++; if (tv[8] | tv[9] | tv[10] | tv[11]) begin
         fails++; $display("FAIL sg_tv got %0b%0b%0b%0b exp 0000", tv[8], tv[9], tv[10], tv[11]);
      end
      tests++; if (bz[10] !== 1'b1 || ps[10] !== 16'd1) begin
         fails++; $display("FAIL sg_gap busy=%0b pkts=%0d exp 1/1", bz[10], ps[10]);
      end
      tests++; if (dn[10] !== 1'b0 || dn[11] !== 1'b1 || dn[12] !== 1'b0) begin
         fails++; $display("FAIL sg_done got %0b%0b%0b exp 010", dn[10], dn[11], dn[12]);
      end
      tests++; if (bz[11] !== 1'b0 || ps[11] !== 16'd1 || tv[12] !== 1'b0) begin
         fails++; $display("FAIL sg_idle busy=%0b pkts=%0d tv=%0b exp 0/1/0", bz[11], ps[11], tv[12]);
      end
   endtask

   task automatic test_reset_mid();
      launch(16'd0, 8'd0, 1'b0);
      record(8, 100, -1, -1, -1, 4);
      tests++; if (tv[4] !== 1'b1 || td[4] !== exp_word(16'd1, 4)) begin
         fails++; $display("FAIL rm_beat4 tv=%0b got %h", tv[4], td[4]);
      end
      tests++; if (tv[5] !== 1'b0 || bz[5] !== 1'b0 || dn[5] !== 1'b0 || ps[5] !== 16'd0 || td[5] !== '0) begin
         fails++; $display("FAIL rm_after tv=%0b busy=%0b done=%0b pkts=%0d exp 0/0/0/0", tv[5], bz[5], dn[5], ps[5]);
      end
      launch(16'd1, 8'd0, 1'b1);
      record(12, 100, -1, -1, -1, -1);
      for (int k = 0; k < LEN; k++) begin
         tests++; if (tv[k] !== 1'b1 || td[k] !== exp_word(16'd1, k)) begin
            fails++; $display("FAIL rm_restart[%0d] tv=%0b got %h exp %h", k, tv[k], td[k], exp_word(16'd1, k));
         end
      end
      tests++; if (dn[LEN] !== 1'b1 || ps[LEN] !== 16'd1 || tv[LEN] !== 1'b0) begin
         fails++; $display("FAIL rm_done done=%0b pkts=%0d tv=%0b exp 1/1/0", dn[LEN], ps[LEN], tv[LEN]);
      end
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; stop = 1'b0;
      num_pkts = 16'd0; gap_cycles = 8'd0; tready = 1'b0;
      test_reset();
      test_basic();
      test_gap();
      test_backpressure();
      test_stop_send();
      test_stop_gap();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
